// File: rtl/adiabatic_pkg.sv
// Shared types for the adiabatic power-clock sequencer: ramp segments, FSM states
// and the per-phase segment rotation.
package adiabatic_pkg;

  typedef enum logic [1:0] {SEG_RISE, SEG_HOLD, SEG_FALL, SEG_WAIT} seg_e;

  typedef enum logic [1:0] {PCS_IDLE, PCS_RUN, PCS_DRAIN} pcs_state_e;

  // Phase k trails the global segment by k quarters; the 2-bit subtraction wraps mod 4.
  function automatic seg_e phase_seg(input logic [1:0] seg, input int k);
    logic [1:0] w_k;
    w_k = k[1:0];
    return seg_e'(seg - w_k);
  endfunction

endpackage

// File: rtl/adiabatic_pclk_phase.sv
// One power-clock rail: turns a local segment/step into a registered trapezoid level
// code plus fully-high / fully-low indicators.
module adiabatic_pclk_phase
  import adiabatic_pkg::*;
#(
  parameter int RAMP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  seg_e              i_seg,
  input  logic [RAMP_W-1:0] i_step,
  input  logic [RAMP_W-1:0] i_s,
  input  logic              i_suppress,
  output logic [RAMP_W-1:0] o_lvl,
  output logic              o_pos,
  output logic              o_neg
);

  logic [RAMP_W-1:0] w_lvl_n;
  logic [RAMP_W-1:0] r_lvl;
  logic              r_pos;
  logic              r_neg;

  always_comb begin
    w_lvl_n = '0;
    if (!i_suppress) begin
      case (i_seg)
        SEG_RISE: w_lvl_n = i_step + RAMP_W'(1);
        SEG_HOLD: w_lvl_n = i_s;
        SEG_FALL: w_lvl_n = i_s - RAMP_W'(1) - i_step;
        default:  w_lvl_n = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lvl <= '0;
      r_pos <= 1'b0;
      r_neg <= 1'b1;
    end else begin
      r_lvl <= w_lvl_n;
      r_pos <= (w_lvl_n == i_s);
      r_neg <= (w_lvl_n == '0);
    end
  end

  assign o_lvl = r_lvl;
  assign o_pos = r_pos;
  assign o_neg = r_neg;

endmodule

// File: rtl/adiabatic_pclk_seq.sv
// Multi-phase adiabatic power-clock sequencer. States: IDLE = rails low, counters held;
// RUN = periodic ramps; DRAIN = finish in-flight falls without starting new rises.
module adiabatic_pclk_seq
  import adiabatic_pkg::*;
#(
  parameter int NPHASE = 4,
  parameter int RAMP_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [RAMP_W-1:0]        ramp_steps,
  output logic [NPHASE*RAMP_W-1:0] pc_lvl,
  output logic [NPHASE-1:0]        pc_pos,
  output logic [NPHASE-1:0]        pc_neg,
  output logic                     busy,
  output logic                     cycle_done,
  output logic [CNT_W-1:0]         period_cnt
);

  localparam logic [1:0] DRAIN_LAST = (NPHASE >= 3) ? 2'(NPHASE - 3) : 2'd0;

  pcs_state_e        r_state, w_state_n;
  logic [1:0]        r_seg, w_seg_n;
  logic [RAMP_W-1:0] r_step, w_step_n;
  logic [RAMP_W-1:0] r_s, w_s_n;
  logic              r_first, w_first_n;
  logic              w_last, w_boundary;
  logic              r_busy, r_cycle_done;
  logic [CNT_W-1:0]  r_period_cnt;

  assign w_last = (r_step == r_s - RAMP_W'(1));

  always_comb begin
    w_state_n  = r_state;
    w_seg_n    = r_seg;
    w_step_n   = r_step;
    w_s_n      = r_s;
    w_first_n  = r_first;
    w_boundary = 1'b0;
    if (r_state != PCS_IDLE) begin
      if (w_last) begin
        w_step_n = '0;
        w_seg_n  = r_seg + 2'd1;
      end else begin
        w_step_n = r_step + RAMP_W'(1);
      end
    end
    case (r_state)
      PCS_IDLE: begin
        if (en) begin
          w_state_n = PCS_RUN;
          w_s_n     = (ramp_steps == '0) ? RAMP_W'(1) : ramp_steps;
          w_first_n = 1'b1;
        end
      end
      PCS_RUN: begin
        if (w_last && (r_seg == 2'd3)) begin
          w_boundary = 1'b1;
          w_first_n  = 1'b0;
          if (!en) w_state_n = (NPHASE >= 3) ? PCS_DRAIN : PCS_IDLE;
        end
      end
      PCS_DRAIN: begin
        if (w_last && (r_seg == DRAIN_LAST)) w_state_n = PCS_IDLE;
      end
      default: w_state_n = PCS_IDLE;
    endcase
    if (w_state_n == PCS_IDLE) begin
      w_seg_n  = 2'd0;
      w_step_n = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= PCS_IDLE;
      r_seg        <= 2'd0;
      r_step       <= '0;
      r_s          <= RAMP_W'(1);
      r_first      <= 1'b0;
      r_busy       <= 1'b0;
      r_cycle_done <= 1'b0;
      r_period_cnt <= '0;
    end else begin
      r_state      <= w_state_n;
      r_seg        <= w_seg_n;
      r_step       <= w_step_n;
      r_s          <= w_s_n;
      r_first      <= w_first_n;
      r_busy       <= (w_state_n != PCS_IDLE);
      r_cycle_done <= w_boundary;
      if (w_boundary) r_period_cnt <= r_period_cnt + CNT_W'(1);
    end
  end

  // A phase stays low until its first rise after start, and never begins a new rise
  // while draining; both keep every rail waveform a clean delayed copy of phase 0.
  for (genvar k = 0; k < NPHASE; k++) begin : g_phase
    logic w_sup;
    assign w_sup = (w_state_n == PCS_IDLE)
                 || (w_first_n && (k > int'(w_seg_n)))
                 || ((w_state_n == PCS_DRAIN) && (k < int'(w_seg_n) + 2));

    adiabatic_pclk_phase #(.RAMP_W(RAMP_W)) u_phase (
      .clk        (clk),
      .rst        (rst),
      .i_seg      (phase_seg(w_seg_n, k)),
      .i_step     (w_step_n),
      .i_s        (w_s_n),
      .i_suppress (w_sup),
      .o_lvl      (pc_lvl[k*RAMP_W +: RAMP_W]),
      .o_pos      (pc_pos[k]),
      .o_neg      (pc_neg[k])
    );
  end

  assign busy       = r_busy;
  assign cycle_done = r_cycle_done;
  assign period_cnt = r_period_cnt;

endmodule

// File: doc/adiabatic_pclk_seq.md
# adiabatic_pclk_seq

Parametrised multi-phase power-clock sequencer for the adiabatic datapath. It generates trapezoidal ramp codes plus the clkpos/clkneg-level indicators that feed the rail drivers of adiabatic cells such as the fan-out inverters. Each phase lags the previous one by one quarter period. Ramp length and channel count are configurable, and shutdown is clean: every phase completes its fall before going idle.

## Interface
Parameters:
- NPHASE, 4, number of power-clock phases; legal 1..4; phase k lags phase 0 by k segments
- RAMP_W, 4, width of ramp step count and level codes
- CNT_W, 16, width of the period counter

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- en  input  1  run request; sampled in IDLE and at period boundaries only
- ramp_steps  input  RAMP_W  segment length S in cycles; 0 treated as 1; latched on IDLE→RUN
- pc_lvl  output  NPHASE*RAMP_W  per-phase ramp level code, phase k at bits [k*RAMP_W +: RAMP_W]
- pc_pos  output  NPHASE  phase k level == S (rail fully high)
- pc_neg  output  NPHASE  phase k level == 0 (rail fully low)
- busy  output  1  state != IDLE
- cycle_done  output  1  one-cycle pulse at each completed period
- period_cnt  output  CNT_W  completed periods since reset, wraps modulo 2^CNT_W

## Operation
- Master FSM states are IDLE, RUN and DRAIN. Global counters: seg (0..3) and step (0..S-1).
- IDLE: counters held at 0. If en=1, the FSM latches S = max(ramp_steps,1) and goes to RUN with seg=0, step=0.
- RUN: step increments each cycle. At step=S-1 it wraps to 0 and seg increments modulo 4.
- Period boundary = seg=3, step=S-1. At a boundary, cycle_done pulses and period_cnt increments.
  - If en=1 at the boundary, the FSM stays in RUN.
  - If en=0 and NPHASE≥3, it goes to DRAIN.
  - If en=0 and NPHASE≤2, it goes to IDLE.
- Phase k local segment = (seg − k) mod 4. Segment meanings:
  - 0 RISE: level = step+1
  - 1 HOLD: level = S
  - 2 FALL: level = S−1−step
  - 3 WAIT: level = 0
- DRAIN: counters keep running and any phase in local RISE is suppressed to level 0. DRAIN lasts NPHASE−2 segments, after which the FSM goes to IDLE with all levels 0.
- en is ignored mid-period and during DRAIN. A new start needs IDLE plus en=1.
- ramp_steps changes take effect only at the next IDLE→RUN.

## Timing
- All outputs are registered and derived from next-state counters.
- pc_lvl[0]=1 appears on the edge that samples en=1 in IDLE. There is no further latency.
- Period = 4·S cycles. Phase k waveform equals phase 0 delayed by k·S cycles.
- cycle_done is high for exactly the cycle following the boundary edge.
- busy falls on the same edge on which all levels return to 0.
- Reset values, applied immediately on rst, independent of clk:
  - FSM = IDLE, counters 0
  - pc_lvl all 0, pc_pos all 0, pc_neg all 1
  - busy 0, cycle_done 0, period_cnt 0
- Reset mid-operation forces all rails low at once. No drain is performed.

## Structure
- Shared package adiabatic_pkg holds:
  - enum seg_e {SEG_RISE, SEG_HOLD, SEG_FALL, SEG_WAIT}
  - enum pcs_state_e {PCS_IDLE, PCS_RUN, PCS_DRAIN}
  - function phase_seg(seg, k)
- Top level contains the FSM, the counters and the period counter.
- One sub-module, adiabatic_pclk_phase, instantiated NPHASE times. Inputs: local segment, step, S, suppress. Outputs: registered level, pos and neg.

## Test plan
- Reset, then en=1, ramp_steps=3 → pc_lvl[0] = 1,2,3,3,3,3,2,1,0,0,0,0,1…; phase 1 identical, delayed 3 cycles; cycle_done every 12 cycles; pc_pos[0] high for 4 consecutive cycles.
- ramp_steps=0, en=1 → S=1, period 4; pc_lvl[0] = 1,1,0,0 repeating; pc_pos[0]=pc_neg[0]' throughout.
- S=2, en dropped at cycle 3 → current period completes; cycle_done at cycle 8; DRAIN for 4 cycles with no new RISE; busy low and all levels 0 by cycle 12; period_cnt=1.
- rst asserted during phase 0 HOLD with S=5 → pc_lvl all 0, pc_neg all 1, busy 0 before next clk edge.
- ramp_steps changed 3→7 mid-run → period stays 12 cycles until stop/restart, then becomes 28 cycles.
- NPHASE=2 build, S=2, en dropped → goes IDLE at the period boundary with no DRAIN; both levels 0.
